// File: rtl/rdmx_stream_arbiter.sv
// Two-input AXI-Stream packet arbiter for the RDMX egress: whole packets only,
// round-robin on ties, one IDLE bubble between packets, per-input packet counters.
module rdmx_stream_arbiter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,

   input  logic [511:0]     AXIS_IN0_TDATA,
   input  logic [63:0]      AXIS_IN0_TKEEP,
   input  logic             AXIS_IN0_TLAST,
   input  logic             AXIS_IN0_TVALID,
   output logic             AXIS_IN0_TREADY,

   input  logic [511:0]     AXIS_IN1_TDATA,
   input  logic [63:0]      AXIS_IN1_TKEEP,
   input  logic             AXIS_IN1_TLAST,
   input  logic             AXIS_IN1_TVALID,
   output logic             AXIS_IN1_TREADY,

   output logic [511:0]     AXIS_OUT_TDATA,
   output logic [63:0]      AXIS_OUT_TKEEP,
   output logic             AXIS_OUT_TLAST,
   output logic             AXIS_OUT_TVALID,
   input  logic             AXIS_OUT_TREADY,

   output logic             busy,
   output logic             grant,
   output logic [CNT_W-1:0] pkt_count0,
   output logic [CNT_W-1:0] pkt_count1
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS0 = 2'd1,
      PASS1 = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_next;
   logic             r_grant;
   logic [CNT_W-1:0] r_cnt0;
   logic [CNT_W-1:0] r_cnt1;

   logic             w_done0;
   logic             w_done1;

   // A packet ends only on its TLAST handshake while it owns the egress.
   assign w_done0 = (r_state == PASS0) & AXIS_IN0_TVALID & AXIS_OUT_TREADY & AXIS_IN0_TLAST;
   assign w_done1 = (r_state == PASS1) & AXIS_IN1_TVALID & AXIS_OUT_TREADY & AXIS_IN1_TLAST;

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (enable) begin
               if (AXIS_IN0_TVALID & AXIS_IN1_TVALID) w_next = r_grant ? PASS0 : PASS1;
               else if (AXIS_IN0_TVALID)              w_next = PASS0;
               else if (AXIS_IN1_TVALID)              w_next = PASS1;
            end
         end
         PASS0:   if (w_done0) w_next = IDLE;
         PASS1:   if (w_done1) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Grant tracks the most recent winner; reset to 1 so input 0 takes the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_grant <= 1'b1;
         r_cnt0  <= '0;
         r_cnt1  <= '0;
      end else begin
         if (r_state == IDLE && w_next == PASS0) r_grant <= 1'b0;
         if (r_state == IDLE && w_next == PASS1) r_grant <= 1'b1;
         if (w_done0) r_cnt0 <= r_cnt0 + CNT_ONE;
         if (w_done1) r_cnt1 <= r_cnt1 + CNT_ONE;
      end
   end

   always_comb begin
      AXIS_OUT_TDATA  = '0;
      AXIS_OUT_TKEEP  = '0;
      AXIS_OUT_TLAST  = 1'b0;
      AXIS_OUT_TVALID = 1'b0;
      AXIS_IN0_TREADY = 1'b0;
      AXIS_IN1_TREADY = 1'b0;
      case (r_state)
         PASS0: begin
            AXIS_OUT_TDATA  = AXIS_IN0_TDATA;
            AXIS_OUT_TKEEP  = AXIS_IN0_TKEEP;
            AXIS_OUT_TLAST  = AXIS_IN0_TLAST;
            AXIS_OUT_TVALID = AXIS_IN0_TVALID;
            AXIS_IN0_TREADY = AXIS_OUT_TREADY;
         end
         PASS1: begin
            AXIS_OUT_TDATA  = AXIS_IN1_TDATA;
            AXIS_OUT_TKEEP  = AXIS_IN1_TKEEP;
            AXIS_OUT_TLAST  = AXIS_IN1_TLAST;
            AXIS_OUT_TVALID = AXIS_IN1_TVALID;
            AXIS_IN1_TREADY = AXIS_OUT_TREADY;
         end
         default: ;
      endcase
   end

   assign busy       = (r_state != IDLE);
   assign grant      = r_grant;
   assign pkt_count0 = r_cnt0;
   assign pkt_count1 = r_cnt1;

endmodule

// File: tb/tb_rdmx_stream_arbiter.sv
// Randomized + directed bench for rdmx_stream_arbiter (CNT_W=4 so counter wrap is reachable).
module tb_rdmx_stream_arbiter;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          r_rst, r_en, r_ordy;
   logic [511:0]  src_d [2];
   logic [63:0]   src_k [2];
   logic          src_l [2];
   logic          src_v [2];

   logic [511:0]  o_data;
   logic [63:0]   o_keep;
   logic          o_last, o_vld, rdy0, rdy1, busy, grant;
   logic [CW-1:0] cnt0, cnt1;

   always #5 clk = ~clk;

   rdmx_stream_arbiter #(.CNT_W(CW)) dut (
      .clk(clk), .reset(r_rst), .enable(r_en),
      .AXIS_IN0_TDATA(src_d[0]), .AXIS_IN0_TKEEP(src_k[0]), .AXIS_IN0_TLAST(src_l[0]),
      .AXIS_IN0_TVALID(src_v[0]), .AXIS_IN0_TREADY(rdy0),
      .AXIS_IN1_TDATA(src_d[1]), .AXIS_IN1_TKEEP(src_k[1]), .AXIS_IN1_TLAST(src_l[1]),
      .AXIS_IN1_TVALID(src_v[1]), .AXIS_IN1_TREADY(rdy1),
      .AXIS_OUT_TDATA(o_data), .AXIS_OUT_TKEEP(o_keep), .AXIS_OUT_TLAST(o_last),
      .AXIS_OUT_TVALID(o_vld), .AXIS_OUT_TREADY(r_ordy),
      .busy(busy), .grant(grant), .pkt_count0(cnt0), .pkt_count1(cnt1)
   );

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got[63:0], exp[63:0], $time);
      end
   endtask

   // Reference: who owns the egress (-1 = nobody), last winner, packet counts.
   int  m_own;
   bit  m_gnt;
   int  m_cnt [2];
   bit  m_known = 1'b0;
   bit  rnd_mode = 1'b0;
   int  pk_rem [2];

   function automatic logic [511:0] rnd512();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic new_beat(input int x, input bit v, input bit l);
      src_v[x] = v;
      src_l[x] = l;
      src_d[x] = rnd512();
      src_k[x] = {$urandom, $urandom};
   endtask

   task automatic start_pkt(input int x, input int len);
      pk_rem[x] = len;
      new_beat(x, 1'b1, len == 1);
   endtask

   task automatic cycle();
      bit hs [2];
      int pick;
      @(negedge clk);
      if (m_known) begin
         chk("busy",  busy,  m_own != -1);
         chk("grant", grant, m_gnt);
         chk("rdy0",  rdy0,  (m_own == 0) ? r_ordy : 1'b0);
         chk("rdy1",  rdy1,  (m_own == 1) ? r_ordy : 1'b0);
         if (m_own == -1) begin
            chk("ovld", o_vld, 0); chk("odata", o_data, 0);
            chk("okeep", o_keep, 0); chk("olast", o_last, 0);
         end else begin
            chk("ovld", o_vld, src_v[m_own]); chk("odata", o_data, src_d[m_own]);
            chk("okeep", o_keep, src_k[m_own]); chk("olast", o_last, src_l[m_own]);
         end
         chk("cnt0", cnt0, m_cnt[0]);
         chk("cnt1", cnt1, m_cnt[1]);
      end
      hs[0] = src_v[0] & rdy0;
      hs[1] = src_v[1] & rdy1;
      if (r_rst) begin
         m_known = 1'b1; m_own = -1; m_gnt = 1'b1; m_cnt[0] = 0; m_cnt[1] = 0;
      end else if (m_own == -1) begin
         if (r_en && (src_v[0] || src_v[1])) begin
            pick  = (src_v[0] && src_v[1]) ? int'(!m_gnt) : (src_v[0] ? 0 : 1);
            m_own = pick;
            m_gnt = pick[0];
         end
      end else if (src_v[m_own] && r_ordy && src_l[m_own]) begin
         m_cnt[m_own] = (m_cnt[m_own] + 1) % (1 << CW);
         m_own = -1;
      end
      @(posedge clk); #1;
      for (int x = 0; x < 2; x++) begin
         if (rnd_mode) begin
            if (!src_v[x] || hs[x]) new_beat(x, ($urandom % 4) != 0, ($urandom % 3) == 0);
         end else if (hs[x]) begin
            pk_rem[x]--;
            if (pk_rem[x] > 0) new_beat(x, 1'b1, pk_rem[x] == 1);
            else               new_beat(x, 1'b0, 1'b0);
         end
      end
   endtask

   task automatic do_reset();
      rnd_mode = 1'b0;
      r_rst = 1'b1; r_en = 1'b1; r_ordy = 1'b1;
      for (int x = 0; x < 2; x++) begin pk_rem[x] = 0; new_beat(x, 1'b0, 1'b0); end
      cycle(); cycle();
      r_rst = 1'b0;
      chk("rst_busy", busy, 0); chk("rst_grant", grant, 1);
      chk("rst_rdy0", rdy0, 0); chk("rst_rdy1", rdy1, 0);
      chk("rst_cnt0", cnt0, 0); chk("rst_cnt1", cnt1, 0);
   endtask

   initial begin
      r_rst = 1'b1; r_en = 1'b1; r_ordy = 1'b1;
      for (int x = 0; x < 2; x++) begin pk_rem[x] = 0; new_beat(x, 1'b0, 1'b0); end
      @(posedge clk); #1;
      do_reset();

      // Simultaneous 3-beat packets: IN0 wins the first tie, IN1 follows after a bubble.
      start_pkt(0, 3); start_pkt(1, 3);
      for (int i = 0; i < 8; i++) cycle();
      chk("r031_cnt0", cnt0, 1); chk("r031_cnt1", cnt1, 1);
      chk("r031_grant", grant, 1); chk("r031_busy", busy, 0);

      // Stalled IN0 packet must not be interleaved with a waiting IN1.
      do_reset();
      start_pkt(0, 4); start_pkt(1, 2);
      for (int i = 0; i < 16; i++) begin r_ordy = (i % 2) == 0; cycle(); end
      r_ordy = 1'b1;
      for (int i = 0; i < 6; i++) cycle();
      chk("r032_cnt0", cnt0, 1); chk("r032_cnt1", cnt1, 1);

      // Disable mid-packet: packet finishes, then hold IDLE until re-enabled.
      do_reset();
      start_pkt(1, 5);
      cycle(); cycle();
      r_en = 1'b0;
      for (int i = 0; i < 4; i++) cycle();
      chk("r033_cnt1", cnt1, 1);
      start_pkt(0, 3); start_pkt(1, 3);
      for (int i = 0; i < 3; i++) cycle();
      chk("r033_idle", busy, 0);
      r_en = 1'b1;
      cycle();
      chk("r033_gnt", grant, 0); chk("r033_busy", busy, 1);
      for (int i = 0; i < 10; i++) cycle();

      // Counter wrap at 2^CW.
      do_reset();
      for (int p = 0; p < 16; p++) begin start_pkt(0, 1); cycle(); cycle(); end
      chk("r034_wrap", cnt0, 0);

      // Reset on beat 2 aborts the packet uncounted; the leftover beats then pass normally.
      do_reset();
      start_pkt(0, 4);
      cycle(); cycle();
      r_rst = 1'b1;
      cycle();
      r_rst = 1'b0;
      chk("r035_busy", busy, 0); chk("r035_cnt0", cnt0, 0); chk("r035_gnt", grant, 1);
      for (int i = 0; i < 5; i++) cycle();
      chk("r035_after", cnt0, 1);

      // Back-to-back single-beat packets on IN1: two cycles each.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         start_pkt(1, 1); cycle(); cycle();
         chk("r036_cnt1", cnt1, k + 1);
      end

      // Random traffic with random backpressure, enable and occasional reset.
      rnd_mode = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         r_ordy = ($urandom % 3) != 0;
         r_en   = ($urandom % 8) != 0;
         r_rst  = ($urandom % 250) == 0;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
